// File: rtl/ysyx_23060111_dmem_responder.sv
// Data-memory responder: slave end of the load/store request channel, modelling a
// word-organised SRAM with programmable access latency and byte-masked writes.
// Latency: request accepted at edge T -> resp_valid from cycle T+LATENCY.
// Backpressure: one transaction in flight; req_ready low outside IDLE, RESP held until resp_ready.
// Optional macro YSYX_23060111_DMEM_ERR_EN: out-of-range addresses return resp_err=1 and
// never touch the array; without it the word index simply wraps modulo DEPTH_WORDS.
module ysyx_23060111_dmem_responder #(
   parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wmask,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        wen_q, wen_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wmask_q, wmask_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   // Storage array; deliberately not reset, like a real SRAM.
   logic [31:0] mem_q [DEPTH_WORDS];

   // Access-side view of the request. With LATENCY==1 the access happens on the
   // accept edge itself, so the live request must be used instead of the latched copy.
   logic        acc_wen;
   logic [31:0] acc_addr;
   logic [31:0] acc_wdata;
   logic [3:0]  acc_wmask;
   logic [31:0] offset;
   logic [IDX_W-1:0] idx;
   logic        in_range;
   logic        access;
   logic        mem_we;
   logic        unused_bits;

   // Select live request data in IDLE, latched data otherwise.
   always_comb begin
      acc_wen   = wen_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_wmask = wmask_q;
      if (state_q == IDLE) begin
         acc_wen   = req_wen;
         acc_addr  = req_addr;
         acc_wdata = req_wdata;
         acc_wmask = req_wmask;
      end
   end

   assign offset = acc_addr - ADDR_BASE;
   assign idx    = offset[IDX_W+1:2];

`ifdef YSYX_23060111_DMEM_ERR_EN
   // Unsigned compare: addresses below the base wrap to huge offsets and fail too.
   assign in_range    = (offset < 32'(4 * DEPTH_WORDS));
   assign unused_bits = ^offset[1:0];
`else
   assign in_range    = 1'b1;
   assign unused_bits = ^{offset[31:IDX_W+2], offset[1:0]};
`endif

   // Next-state, handshake outputs and the single-cycle array access.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      wen_d      = wen_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wmask_d    = wmask_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      access     = 1'b0;
      mem_we     = 1'b0;
      req_ready  = 1'b0;
      resp_valid = 1'b0;

      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               wen_d   = req_wen;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               wmask_d = req_wmask;
               cnt_d   = 4'(LATENCY - 1);
               if (LATENCY == 1) begin
                  access  = 1'b1;
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               access  = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               state_d = IDLE;
               rdata_d = 32'h0;
               err_d   = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Read data is captured here so it stays stable for the whole RESP phase;
      // write responses and errored accesses always return zero data.
      if (access) begin
         err_d   = ~in_range;
         mem_we  = acc_wen & in_range;
         rdata_d = (!acc_wen && in_range) ? mem_q[idx] : 32'h0;
      end
   end

   // Control and response registers, synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         wen_q   <= 1'b0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         wmask_q <= 4'h0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wen_q   <= wen_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Byte-lane write port; a zero mask leaves the word untouched.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         for (int b = 0; b < 4; b++) begin
            if (acc_wmask[b]) begin
               mem_q[idx][8*b +: 8] <= acc_wdata[8*b +: 8];
            end
         end
      end
   end

   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule

// File: tb/tb_ysyx_23060111_dmem_responder.sv
// Directed bench for the data-memory responder: three instances with latencies 3, 1 and 4
// share one clock; each scenario task drives one instance and checks its own results.
module tb_ysyx_23060111_dmem_responder;

   logic        clk;
   logic        rst        [3];
   logic        req_valid  [3];
   logic        req_ready  [3];
   logic        req_wen    [3];
   logic [31:0] req_addr   [3];
   logic [31:0] req_wdata  [3];
   logic [3:0]  req_wmask  [3];
   logic        resp_valid [3];
   logic        resp_ready [3];
   logic [31:0] resp_rdata [3];
   logic        resp_err   [3];

   int n_checks = 0;
   int n_fail   = 0;

   ysyx_23060111_dmem_responder #(.LATENCY(3)) u_l3 (
      .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_wen(req_wen[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .req_wmask(req_wmask[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
      .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

   ysyx_23060111_dmem_responder #(.LATENCY(1)) u_l1 (
      .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_wen(req_wen[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .req_wmask(req_wmask[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
      .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

   ysyx_23060111_dmem_responder #(.LATENCY(4)) u_l4 (
      .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
      .req_wen(req_wen[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
      .req_wmask(req_wmask[2]), .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
      .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One full transaction on instance i. lat counts edges from the accept edge to the first
   // cycle with resp_valid; busy_ok says req_ready was low throughout; during 'hold' cycles
   // resp_ready is kept low while a stray write request is offered; idle_ok says the
   // instance is back to accepting after the response handshake.
   task automatic do_txn(input int i, input logic wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] mask, input int hold,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output logic busy_ok, output logic hold_ok, output logic idle_ok);
      @(negedge clk);
      req_valid[i]  = 1'b1;
      req_wen[i]    = wen;
      req_addr[i]   = addr;
      req_wdata[i]  = wdata;
      req_wmask[i]  = mask;
      resp_ready[i] = 1'b0;
      busy_ok = req_ready[i];
      @(negedge clk);
      req_valid[i] = 1'b0;
      lat = 1;
      while (!resp_valid[i] && lat < 40) begin
         if (req_ready[i]) busy_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      if (req_ready[i]) busy_ok = 1'b0;
      rdata   = resp_rdata[i];
      err     = resp_err[i];
      hold_ok = 1'b1;
      for (int k = 0; k < hold; k++) begin
         req_valid[i] = 1'b1;
         req_wen[i]   = 1'b1;
         req_addr[i]  = 32'h8000_0010;
         req_wdata[i] = 32'hFFFF_FFFF;
         req_wmask[i] = 4'hF;
         @(negedge clk);
         if (!resp_valid[i] || req_ready[i] || resp_rdata[i] !== rdata || resp_err[i] !== err)
            hold_ok = 1'b0;
      end
      req_valid[i]  = 1'b0;
      resp_ready[i] = 1'b1;
      @(negedge clk);
      resp_ready[i] = 1'b0;
      idle_ok = req_ready[i] && !resp_valid[i];
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         rst[i] = 1'b1; req_valid[i] = 1'b0; req_wen[i] = 1'b0; req_addr[i] = 32'h0;
         req_wdata[i] = 32'h0; req_wmask[i] = 4'h0; resp_ready[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) rst[i] = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (req_ready[i] !== 1'b1) begin
            n_fail++; $display("FAIL reset_req_ready[%0d]: got %b want 1", i, req_ready[i]);
         end
         n_checks++;
         if (resp_valid[i] !== 1'b0) begin
            n_fail++; $display("FAIL reset_resp_valid[%0d]: got %b want 0", i, resp_valid[i]);
         end
         n_checks++;
         if (resp_rdata[i] !== 32'h0) begin
            n_fail++; $display("FAIL reset_rdata[%0d]: got %h want 0", i, resp_rdata[i]);
         end
         n_checks++;
         if (resp_err[i] !== 1'b0) begin
            n_fail++; $display("FAIL reset_err[%0d]: got %b want 0", i, resp_err[i]);
         end
      end
   endtask

   task automatic test_write_read();
      logic [31:0] rd; logic er, b_ok, h_ok, i_ok; int lat;
      do_txn(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, rd, er, lat, b_ok, h_ok, i_ok);
      n_checks++;
      if (rd !== 32'h0 || er !== 1'b0) begin
         n_fail++; $display("FAIL wr_resp: got rdata %h err %b want 0 0", rd, er);
      end
      n_checks++;
      if (lat != 3) begin
         n_fail++; $display("FAIL wr_latency: got %0d want 3", lat);
      end
      do_txn(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, rd, er, lat, b_ok, h_ok, i_ok);
      n_checks++;
      if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
         n_fail++; $display("FAIL rd_after_wr: got %h err %b want deadbeef 0", rd, er);
      end
      n_checks++;
      if (i_ok !== 1'b1) begin
         n_fail++; $display("FAIL rd_back_to_idle: got %b want 1", i_ok);
      end
   endtask

   task automatic test_byte_mask();
      logic [31:0] rd; logic er, b_ok, h_ok, i_ok; int lat;
      do_txn(0, 1'b1, 32'h8000_0010, 32'h0000_AB00, 4'h2, 0, rd, er, lat, b_ok, h_ok, i_ok);
      do_txn(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, rd, er, lat, b_ok, h_ok, i_ok);
      n_checks++;
      if (rd !== 32'hDEAD_ABEF) begin
         n_fail++; $display("FAIL byte_mask: got %h want deadabef", rd);
      end
      // Zero mask: still answered with normal latency, array untouched.
      do_txn(0, 1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 0, rd, er, lat, b_ok, h_ok, i_ok);
      n_checks++;
      if (lat != 3) begin
         n_fail++; $display("FAIL zero_mask_latency: got %0d want 3", lat);
      end
      do_txn(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, rd, er, lat, b_ok, h_ok, i_ok);
      n_checks++;
      if (rd !== 32'hDEAD_ABEF) begin
         n_fail++; $display("FAIL zero_mask_data: got %h want deadabef", rd);
      end
   endtask

   task automatic test_latency();
      logic [31:0] rd; logic er, b_ok, h_ok, i_ok; int lat;
      do_txn(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, rd, er, lat, b_ok, h_ok, i_ok);
      n_checks++;
      if (lat != 3 || b_ok !== 1'b1) begin
         n_fail++; $display("FAIL latency3: got lat %0d busy_ok %b want 3 1", lat, b_ok);
      end
      do_txn(1, 1'b1, 32'h8000_0004, 32'h0102_0304, 4'hF, 0, rd, er, lat, b_ok, h_ok, i_ok);
      n_checks++;
      if (lat != 1 || b_ok !== 1'b1) begin
         n_fail++; $display("FAIL latency1_wr: got lat %0d busy_ok %b want 1 1", lat, b_ok);
      end
      do_txn(1, 1'b0, 32'h8000_0004, 32'h0, 4'h0, 0, rd, er, lat, b_ok, h_ok, i_ok);
      n_checks++;
      if (rd !== 32'h0102_0304 || lat != 1) begin
         n_fail++; $display("FAIL latency1_rd: got %h lat %0d want 01020304 1", rd, lat);
      end
      n_checks++;
      if (i_ok !== 1'b1) begin
         n_fail++; $display("FAIL latency1_idle: got %b want 1", i_ok);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] rd; logic er, b_ok, h_ok, i_ok; int lat;
      do_txn(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 4, rd, er, lat, b_ok, h_ok, i_ok);
      n_checks++;
      if (h_ok !== 1'b1) begin
         n_fail++; $display("FAIL bp_stable: got %b want 1", h_ok);
      end
      n_checks++;
      if (rd !== 32'hDEAD_ABEF) begin
         n_fail++; $display("FAIL bp_data: got %h want deadabef", rd);
      end
      n_checks++;
      if (i_ok !== 1'b1) begin
         n_fail++; $display("FAIL bp_idle: got %b want 1", i_ok);
      end
      // The write offered during backpressure must have been ignored.
      do_txn(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, rd, er, lat, b_ok, h_ok, i_ok);
      n_checks++;
      if (rd !== 32'hDEAD_ABEF) begin
         n_fail++; $display("FAIL bp_no_accept: got %h want deadabef", rd);
      end
   endtask

   task automatic test_range();
      logic [31:0] rd; logic er, b_ok, h_ok, i_ok; int lat;
      do_txn(0, 1'b1, 32'h8000_0000, 32'h0BAD_F00D, 4'hF, 0, rd, er, lat, b_ok, h_ok, i_ok);
`ifdef YSYX_23060111_DMEM_ERR_EN
      do_txn(0, 1'b0, 32'h0000_0000, 32'h0, 4'h0, 0, rd, er, lat, b_ok, h_ok, i_ok);
      n_checks++;
      if (er !== 1'b1 || rd !== 32'h0 || lat != 3) begin
         n_fail++; $display("FAIL err_low: got err %b rdata %h lat %0d want 1 0 3", er, rd, lat);
      end
      do_txn(0, 1'b1, 32'h8000_1000, 32'h5555_5555, 4'hF, 0, rd, er, lat, b_ok, h_ok, i_ok);
      n_checks++;
      if (er !== 1'b1) begin
         n_fail++; $display("FAIL err_high: got %b want 1", er);
      end
      do_txn(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, rd, er, lat, b_ok, h_ok, i_ok);
      n_checks++;
      if (rd !== 32'h0BAD_F00D || er !== 1'b0) begin
         n_fail++; $display("FAIL err_word0: got %h err %b want 0badf00d 0", rd, er);
      end
`else
      do_txn(0, 1'b1, 32'h8000_1010, 32'hCAFE_F00D, 4'hF, 0, rd, er, lat, b_ok, h_ok, i_ok);
      n_checks++;
      if (er !== 1'b0) begin
         n_fail++; $display("FAIL wrap_wr_err: got %b want 0", er);
      end
      do_txn(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, rd, er, lat, b_ok, h_ok, i_ok);
      n_checks++;
      if (rd !== 32'hCAFE_F00D || er !== 1'b0) begin
         n_fail++; $display("FAIL wrap_wr: got %h err %b want cafef00d 0", rd, er);
      end
      do_txn(0, 1'b0, 32'h0000_0000, 32'h0, 4'h0, 0, rd, er, lat, b_ok, h_ok, i_ok);
      n_checks++;
      if (rd !== 32'h0BAD_F00D || er !== 1'b0) begin
         n_fail++; $display("FAIL wrap_rd: got %h err %b want 0badf00d 0", rd, er);
      end
`endif
   endtask

   task automatic test_reset_wait();
      logic [31:0] rd; logic er, b_ok, h_ok, i_ok; int lat; logic seen_valid;
      do_txn(2, 1'b1, 32'h8000_0020, 32'h1111_2222, 4'hF, 0, rd, er, lat, b_ok, h_ok, i_ok);
      n_checks++;
      if (lat != 4) begin
         n_fail++; $display("FAIL l4_latency: got %0d want 4", lat);
      end
      @(negedge clk);
      req_valid[2] = 1'b1; req_wen[2] = 1'b1; req_addr[2] = 32'h8000_0020;
      req_wdata[2] = 32'h1234_5678; req_wmask[2] = 4'hF;
      @(negedge clk);
      req_valid[2] = 1'b0;
      rst[2] = 1'b1;
      @(negedge clk);
      rst[2] = 1'b0;
      n_checks++;
      if (req_ready[2] !== 1'b1 || resp_valid[2] !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_wait_state: got ready %b valid %b want 1 0", req_ready[2], resp_valid[2]);
      end
      seen_valid = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (resp_valid[2]) seen_valid = 1'b1;
      end
      n_checks++;
      if (seen_valid !== 1'b0) begin
         n_fail++; $display("FAIL rst_wait_no_resp: got %b want 0", seen_valid);
      end
      do_txn(2, 1'b0, 32'h8000_0020, 32'h0, 4'h0, 0, rd, er, lat, b_ok, h_ok, i_ok);
      n_checks++;
      if (rd !== 32'h1111_2222) begin
         n_fail++; $display("FAIL rst_wait_no_write: got %h want 11112222", rd);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_byte_mask();
      test_latency();
      test_backpressure();
      test_range();
      test_reset_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ysyx_23060111_dmem_responder.md
# ysyx_23060111_dmem_responder

Data-memory responder: the slave end of the core's load/store request interface. Accepts one read or write request at a time over a valid/ready handshake and models a word-organised data SRAM with programmable access latency and byte-masked writes. Returns read data or a write acknowledge over a second valid/ready channel. Sits between the execute/load-store stage and simulation memory, replacing the zero-latency combinational memory path so the core can be exercised against multi-cycle memory.

## Interface
Parameters:
- ADDR_BASE, 32'h8000_0000: byte address of word 0.
- DEPTH_WORDS, 1024: number of 32-bit words; power of two.
- LATENCY, 2: cycles from request accept to response valid; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_wen  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address; bits [1:0] ignored.
- req_wdata  in  32  write data, byte lanes aligned to the address word.
- req_wmask  in  4  byte enables; bit i enables wdata[8i+7:8i].
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  32  read data; 0 for write responses.
- resp_err  out  1  access error (see Configuration).

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid && req_ready, latch wen, addr, wdata, wmask; load counter with LATENCY-1. If LATENCY==1, go directly to RESP; otherwise go to WAIT.
- WAIT: req_ready=0. Decrement counter each cycle. When the counter reaches 1, perform the access and go to RESP.
- Access (single cycle, at the transition into RESP):
  - Word index = (addr - ADDR_BASE) >> 2, truncated to log2(DEPTH_WORDS) bits.
  - Write: update only the byte lanes set in wmask. A wmask of 0 writes nothing but still responds.
  - Read: resp_rdata registered from the array. Reads see all previously completed writes.
- RESP: resp_valid=1, and outputs stay stable until resp_ready. On resp_valid && resp_ready, go to IDLE. No new request is accepted in the same cycle (req_ready stays 0 during RESP).
- Only one transaction is outstanding at a time; no pipelining of requests.

## Timing
- Reset values: req_ready=1 (state IDLE), resp_valid=0, resp_rdata=0, resp_err=0, counter=0. Memory contents are not reset.
- Request accepted at edge T gives resp_valid=1 from cycle T+LATENCY.
- Minimum turnaround is LATENCY+1 cycles per transaction when resp_ready is held high.
- Backpressure: resp_ready low holds RESP indefinitely with rdata/err stable.
- Reset mid-operation (WAIT): the transaction is dropped and no write occurs.
- Reset in RESP: the write has already completed; the response is discarded.
- req_* inputs are ignored outside IDLE.

## Configuration
- Macro YSYX_23060111_DMEM_ERR_EN.
- Defined: an address outside [ADDR_BASE, ADDR_BASE + 4*DEPTH_WORDS) produces a response with resp_err=1 and resp_rdata=0. No array write occurs. Latency is unchanged.
- Undefined: no range check; the index wraps modulo DEPTH_WORDS and resp_err is tied to 0.

## Test plan
- Write then read: write 0xDEADBEEF, mask 0xF, to 0x8000_0010, then read 0x8000_0010 -> resp_rdata=0xDEADBEEF, resp_err=0.
- Byte mask: after the above, write 0x0000AB00 with mask 0x2 to 0x8000_0010, then read -> 0xDEADABEF.
- Latency: with LATENCY=3, accept at cycle 10 -> resp_valid first high at cycle 13; with LATENCY=1 -> cycle 11; req_ready low from cycle 11 until response handshake.
- Backpressure: hold resp_ready=0 for 4 cycles in RESP -> resp_valid and resp_rdata stable; a req_valid asserted meanwhile is not accepted.
- Error (macro defined): read 0x0000_0000 -> resp_err=1, resp_rdata=0; write to 0x8000_1000 (DEPTH_WORDS=1024) -> resp_err=1, and word 0 is unchanged.
- Reset in WAIT: issue a write of 0x12345678 to 0x8000_0020 with LATENCY=4, assert rst one cycle after accept -> req_ready=1 and resp_valid=0 next cycle; a later read of 0x8000_0020 returns the prior contents.
